// File: rtl/if_stage_pkg.sv
// Shared constants, IF/ID register layout and helpers for the instruction-fetch stage.
package if_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0340_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        FETCH_RUN      = 2'd0,
        FETCH_STOP     = 2'd1,
        FETCH_REDIRECT = 2'd2
    } fetch_mode_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } ifid_t;

    function automatic ifid_t ifid_bubble();
        ifid_t b;
        b.pc    = 32'h0;
        b.inst  = NOP_INST;
        b.valid = 1'b0;
        return b;
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid that catches the ROM word arriving while the stage is stopped,
// so the word survives the ROM output changing before fetch resumes.
module fetch_skid
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stop,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic [31:0] out_data
);

    logic        sk_valid_q, sk_valid_d;
    logic [31:0] sk_inst_q, sk_inst_d;

    always_comb begin
        sk_valid_d = sk_valid_q;
        sk_inst_d  = sk_inst_q;
        if (flush) begin
            sk_valid_d = 1'b0;
        end else if (stop) begin
            // Only the first stop cycle carries fresh ROM data; later ones keep it.
            if (in_valid && !sk_valid_q) begin
                sk_valid_d = 1'b1;
                sk_inst_d  = in_data;
            end
        end else begin
            sk_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sk_valid_q <= 1'b0;
            sk_inst_q  <= NOP_INST;
        end else begin
            sk_valid_q <= sk_valid_d;
            sk_inst_q  <= sk_inst_d;
        end
    end

    assign out_data = sk_valid_q ? sk_inst_q : in_data;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives the one-cycle-latency ROM and loads IF/ID.
// Redirect beats stop beats normal fetch.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        pipeline_stop,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        irom_en,
    output logic [31:0] irom_addr,
    input  logic [31:0] irom_inst,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_valid
);

    fetch_mode_e mode;
    logic [31:0] redirect_tgt;
    logic [31:0] fetched_inst;

    logic [31:0] pc_q, pc_d;
    logic        f2_valid_q, f2_valid_d;
    logic [31:0] f2_pc_q, f2_pc_d;
    ifid_t       ifid_q, ifid_d;

    assign redirect_tgt = align_word(redirect_pc);

    always_comb begin
        if (redirect_valid)     mode = FETCH_REDIRECT;
        else if (pipeline_stop) mode = FETCH_STOP;
        else                    mode = FETCH_RUN;
    end

    fetch_skid u_skid (
        .clk      (cpu_clk),
        .rst_n    (cpu_rst_n),
        .stop     (pipeline_stop),
        .flush    (redirect_valid),
        .in_valid (f2_valid_q),
        .in_data  (irom_inst),
        .out_data (fetched_inst)
    );

    always_comb begin
        pc_d       = pc_q;
        f2_valid_d = f2_valid_q;
        f2_pc_d    = f2_pc_q;
        ifid_d     = ifid_q;
        irom_en    = 1'b1;
        irom_addr  = pc_q;
        case (mode)
            FETCH_REDIRECT: begin
                irom_addr  = redirect_tgt;
                pc_d       = redirect_tgt + PC_STEP;
                f2_pc_d    = redirect_tgt;
                f2_valid_d = 1'b1;
                ifid_d     = ifid_bubble();
            end
            FETCH_STOP: begin
                irom_en = 1'b0;
            end
            FETCH_RUN: begin
                pc_d       = pc_q + PC_STEP;
                f2_pc_d    = pc_q;
                f2_valid_d = 1'b1;
                if (f2_valid_q) begin
                    ifid_d.pc    = f2_pc_q + PC_STEP;
                    ifid_d.inst  = fetched_inst;
                    ifid_d.valid = 1'b1;
                end else begin
                    ifid_d = ifid_bubble();
                end
            end
            default: ;
        endcase
        // Keep the ROM pointed at the boot address while held in reset.
        if (!cpu_rst_n) begin
            irom_en   = 1'b1;
            irom_addr = RESET_PC;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            pc_q       <= RESET_PC;
            f2_valid_q <= 1'b0;
            f2_pc_q    <= RESET_PC;
            ifid_q     <= ifid_bubble();
        end else begin
            pc_q       <= pc_d;
            f2_valid_q <= f2_valid_d;
            f2_pc_q    <= f2_pc_d;
            ifid_q     <= ifid_d;
        end
    end

    assign IF_ID_pc    = ifid_q.pc;
    assign IF_ID_inst  = ifid_q.inst;
    assign IF_ID_valid = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID entries are queued per step and
// compared after the clock edge; ROM fetch interface checked before the edge.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0340_0000;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n;
    logic        pipeline_stop;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        irom_en;
    logic [31:0] irom_addr;
    logic [31:0] irom_inst = 32'h0;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_inst;
    logic        IF_ID_valid;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];

    if_stage dut (
        .cpu_clk        (cpu_clk),
        .cpu_rst_n      (cpu_rst_n),
        .pipeline_stop  (pipeline_stop),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .irom_en        (irom_en),
        .irom_addr      (irom_addr),
        .irom_inst      (irom_inst),
        .IF_ID_pc       (IF_ID_pc),
        .IF_ID_inst     (IF_ID_inst),
        .IF_ID_valid    (IF_ID_valid)
    );

    always #5 cpu_clk = ~cpu_clk;

    // ROM contents: word k holds k+1, except word 0x40 holds 0xAA.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        logic [31:0] k;
        k = addr >> 2;
        return (k == 32'h40) ? 32'h0000_00AA : k + 32'd1;
    endfunction

    always @(posedge cpu_clk) begin
        if (irom_en) irom_inst <= rom_word(irom_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, expv);
        end
    endtask

    // rom_chk: 0 = no ROM check, 1 = irom_en only, 2 = irom_en and irom_addr
    task automatic step(input logic stop, input logic redir, input logic [31:0] rpc,
                        input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_valid,
                        input int rom_chk, input logic e_en, input logic [31:0] e_addr);
        exp_t e;
        step_no++;
        pipeline_stop  = stop;
        redirect_valid = redir;
        redirect_pc    = rpc;
        e.pc    = e_pc;
        e.inst  = e_inst;
        e.valid = e_valid;
        exp_q.push_back(e);
        #1;
        if (rom_chk >= 1) check("irom_en", 32'(irom_en), 32'(e_en));
        if (rom_chk >= 2) check("irom_addr", irom_addr, e_addr);
        @(posedge cpu_clk);
        #1;
        e = exp_q.pop_front();
        check("ifid_pc", IF_ID_pc, e.pc);
        check("ifid_inst", IF_ID_inst, e.inst);
        check("ifid_valid", 32'(IF_ID_valid), 32'(e.valid));
    endtask

    initial begin
        cpu_rst_n      = 1'b0;
        pipeline_stop  = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge cpu_clk);
        #1;
        check("rst_irom_en", 32'(irom_en), 32'd1);
        check("rst_irom_addr", irom_addr, 32'h0);
        check("rst_ifid_pc", IF_ID_pc, 32'h0);
        check("rst_ifid_inst", IF_ID_inst, NOP);
        check("rst_ifid_valid", 32'(IF_ID_valid), 32'd0);
        cpu_rst_n = 1'b1;

        // start-up and straight-line fetch
        step(0, 0, 0, 32'h0,  NOP,   0, 2, 1, 32'h0);
        step(0, 0, 0, 32'h4,  32'd1, 1, 2, 1, 32'h4);
        step(0, 0, 0, 32'h8,  32'd2, 1, 2, 1, 32'h8);
        // stop for 3 cycles with 0x8 in flight
        step(1, 0, 0, 32'h8,  32'd2, 1, 1, 0, 32'h0);
        step(1, 0, 0, 32'h8,  32'd2, 1, 1, 0, 32'h0);
        step(1, 0, 0, 32'h8,  32'd2, 1, 1, 0, 32'h0);
        step(0, 0, 0, 32'hC,  32'd3, 1, 2, 1, 32'hC);
        step(0, 0, 0, 32'h10, 32'd4, 1, 2, 1, 32'h10);
        step(0, 0, 0, 32'h14, 32'd5, 1, 2, 1, 32'h14);
        step(0, 0, 0, 32'h18, 32'd6, 1, 2, 1, 32'h18);
        // redirect to 0x100
        step(0, 1, 32'h100, 32'h0,   NOP,          0, 2, 1, 32'h100);
        step(0, 0, 0,       32'h104, 32'h0000_00AA, 1, 2, 1, 32'h104);
        step(0, 0, 0,       32'h108, 32'h42,        1, 2, 1, 32'h108);
        step(0, 0, 0,       32'h10C, 32'h43,        1, 2, 1, 32'h10C);
        // fill the skid, then redirect+stop with a misaligned target
        step(1, 0, 0,       32'h10C, 32'h43,        1, 1, 0, 32'h0);
        step(1, 0, 0,       32'h10C, 32'h43,        1, 1, 0, 32'h0);
        step(1, 1, 32'h102, 32'h0,   NOP,           0, 2, 1, 32'h100);
        step(0, 0, 0,       32'h104, 32'h0000_00AA, 1, 2, 1, 32'h104);
        step(0, 0, 0,       32'h108, 32'h42,        1, 2, 1, 32'h108);
        // PC wrap at the top of the address space
        step(0, 1, 32'hFFFF_FFFC, 32'h0, NOP,          0, 2, 1, 32'hFFFF_FFFC);
        step(0, 0, 0,             32'h0, 32'h4000_0000, 1, 2, 1, 32'h0);
        step(0, 0, 0,             32'h4, 32'd1,        1, 2, 1, 32'h4);
        // skid full, then asynchronous reset pulse mid-cycle
        step(1, 0, 0,             32'h4, 32'd1,        1, 1, 0, 32'h0);
        cpu_rst_n = 1'b0;
        #1;
        check("mid_rst_irom_en", 32'(irom_en), 32'd1);
        check("mid_rst_irom_addr", irom_addr, 32'h0);
        check("mid_rst_ifid_pc", IF_ID_pc, 32'h0);
        check("mid_rst_ifid_inst", IF_ID_inst, NOP);
        check("mid_rst_ifid_valid", 32'(IF_ID_valid), 32'd0);
        #1;
        cpu_rst_n = 1'b1;
        step(0, 0, 0, 32'h0, NOP,   0, 2, 1, 32'h0);
        step(0, 0, 0, 32'h4, 32'd1, 1, 2, 1, 32'h4);
        step(0, 0, 0, 32'h8, 32'd2, 1, 2, 1, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
